spi_burst_sequencer: RTL and testbench
======================================

Name: spi_burst_sequencer

Overview:
- Upstream feeder and collector for one spi_master instance.
- The host pushes words into a TX FIFO. The sequencer drains them one at a time into spi_master via the go/datai/busy/done handshake.
- Each full-duplex word returned on spi_master datao is pushed into an RX FIFO for the host to read.
- Turns single-word spi_master transfers into back-to-back bursts with no host cycle-by-cycle control.

Parameters:
- DATA_WIDTH, 8, word width; must match the attached spi_master.
- FIFO_DEPTH, 8, entries per FIFO; power of two, at least 2.
- ADDR_WIDTH, 3, log2(FIFO_DEPTH).

Ports:
- clk  in  1  system clock; all logic on the rising edge.
- resetb  in  1  asynchronous active-low reset.
- enable  in  1  level; while high, the sequencer drains the TX FIFO.
- tx_wr  in  1  push tx_data into the TX FIFO.
- tx_data  in  DATA_WIDTH  word to transmit.
- tx_full  out  1  TX FIFO full.
- tx_level  out  ADDR_WIDTH+1  TX occupancy.
- rx_rd  in  1  pop the RX FIFO head.
- rx_data  out  DATA_WIDTH  RX FIFO head; valid when !rx_empty.
- rx_empty  out  1  RX FIFO empty.
- rx_level  out  ADDR_WIDTH+1  RX occupancy.
- tx_overflow  out  1  sticky; a write was attempted while full.
- rx_overflow  out  1  sticky; a received word was dropped because the RX FIFO was full.
- clear_err  in  1  clears both sticky flags.
- seq_busy  out  1  state != IDLE.
- spi_go  out  1  one-cycle start pulse to spi_master.
- spi_datai  out  DATA_WIDTH  word presented to spi_master.
- spi_busy  in  1  spi_master busy.
- spi_done  in  1  spi_master done pulse; spi_datao is valid in that cycle.
- spi_datao  in  DATA_WIDTH  word received by spi_master.

Behaviour:
- Reset (async, resetb=0):
  - FIFOs empty; pointers 0.
  - state=IDLE.
  - spi_go=0, spi_datai=0, seq_busy=0, tx_overflow=0, rx_overflow=0.
  - tx_full=0, tx_level=0, rx_empty=1, rx_level=0, rx_data=0.
- Reset mid-transfer: abandons the word. The attached spi_master shares resetb, so nothing is left dangling.
- FSM states and transitions:
  - IDLE: go to LOAD if enable && tx_level!=0.
  - LOAD: pop the TX head into the spi_datai register; go to GO.
  - GO: spi_go=1 for exactly this cycle; go to ARM.
  - ARM: go to XFER when spi_busy=1. If spi_done=1 arrives first (very short transfer), treat it as XFER completion.
  - XFER: on spi_done=1, capture spi_datao; go to STORE.
  - STORE: push the captured word into the RX FIFO, or drop it and set rx_overflow if the RX FIFO is full; go to IDLE.
- Latency: a tx_wr in cycle N into an empty FIFO with enable=1 gives LOAD in N+1 and spi_go in N+2.
- Back-to-back: there is a 2-cycle gap (STORE, IDLE) after done before the next LOAD. This lets spi_master return to idle.
- spi_datai stays constant from LOAD until the next LOAD.
- enable deasserted mid-word: the current word completes through STORE; then the FSM holds in IDLE.
- FIFO rules:
  - Circular buffers with ADDR_WIDTH+1-bit pointers.
  - full = (MSBs differ && lower bits equal); empty = (pointers equal).
  - Pointers wrap naturally.
  - tx_wr while full: word dropped, tx_overflow=1.
  - tx_wr concurrent with an internal pop on a full FIFO: the write is accepted (the pop frees a slot).
  - rx_rd while empty: ignored, no flag.
  - Concurrent RX push and rx_rd: both take effect; level unchanged.
- rx_data: combinational read of the head entry; holds its last value when empty.
- clear_err: clears both sticky flags. A set event in the same cycle wins.

Decomposition:
- Package spi_seq_pkg:
  - FSM state encoding localparams: IDLE, LOAD, GO, ARM, XFER, STORE.
  - Default DATA_WIDTH and FIFO_DEPTH constants.
- Sub-module spi_sync_fifo (parameterised DATA_WIDTH, ADDR_WIDTH; ports wr/wdata/rd/rdata/full/empty/level/overflow), instantiated twice for TX and RX.
- The FSM lives in spi_burst_sequencer.

Test Plan:
- Reset: hold resetb=0 with tx_wr pulsing → levels 0, rx_empty=1, spi_go never 1. Release → still IDLE while enable=0.
- Single word: with a slave model returning 0x11, push 0xA5 with enable=1 → spi_go 2 cycles later, spi_datai=0xA5; after done, rx_level=1, rx_data=0x11.
- Burst: push 0x01..0x08 (fills depth 8, tx_full=1), enable=1 → 8 spi_go pulses in order; RX contains the slave words in order; tx_overflow=0.
- Overflow: push 9 words with enable=0 → tx_overflow=1, 9th word dropped. Drain 8 without reading RX, then send 1 more → rx_overflow=1, rx_level=8. clear_err → both flags 0.
- Enable drop: deassert enable during XFER of word 2 of 4 → word 2 completes and is stored, no further spi_go; re-enable → words 3 and 4 proceed.
- Async reset mid-XFER: resetb=0 for 3 cycles → all outputs return to reset values immediately (not at the next edge), FIFOs empty.

Source files
------------

// File: rtl/spi_seq_pkg.sv
// Shared constants and FSM state encoding for the SPI burst sequencer.
package spi_seq_pkg;

   localparam int DEF_DATA_WIDTH = 8;
   localparam int DEF_FIFO_DEPTH = 8;

   typedef enum logic [2:0] {
      IDLE  = 3'd0,
      LOAD  = 3'd1,
      GO    = 3'd2,
      ARM   = 3'd3,
      XFER  = 3'd4,
      STORE = 3'd5
   } seq_state_e;

endpackage

// File: rtl/spi_sync_fifo.sv
// Single-clock circular FIFO with extra-MSB pointers and a sticky overflow flag.
module spi_sync_fifo #(
   parameter int DATA_WIDTH = 8,
   parameter int ADDR_WIDTH = 3
) (
   input  logic                  clk,
   input  logic                  resetb,
   input  logic                  wr,
   input  logic [DATA_WIDTH-1:0] wdata,
   input  logic                  rd,
   output logic [DATA_WIDTH-1:0] rdata,
   output logic                  full,
   output logic                  empty,
   output logic [ADDR_WIDTH:0]   level,
   output logic                  overflow,
   input  logic                  clr
);

   localparam int DEPTH = 1 << ADDR_WIDTH;
   localparam logic [ADDR_WIDTH:0] PTR_ONE = {{ADDR_WIDTH{1'b0}}, 1'b1};

   logic [DATA_WIDTH-1:0] mem_q [DEPTH];
   logic [ADDR_WIDTH:0]   wr_ptr_q, wr_ptr_d;
   logic [ADDR_WIDTH:0]   rd_ptr_q, rd_ptr_d;
   logic [DATA_WIDTH-1:0] last_q, last_d;
   logic                  ovf_q, ovf_d;
   logic                  wr_ok, rd_ok;
   logic [DATA_WIDTH-1:0] head;

   assign full     = (wr_ptr_q[ADDR_WIDTH] != rd_ptr_q[ADDR_WIDTH]) &&
                     (wr_ptr_q[ADDR_WIDTH-1:0] == rd_ptr_q[ADDR_WIDTH-1:0]);
   assign empty    = (wr_ptr_q == rd_ptr_q);
   assign level    = wr_ptr_q - rd_ptr_q;
   assign head     = mem_q[rd_ptr_q[ADDR_WIDTH-1:0]];
   // Once drained, the head slot may be stale; show the last word popped instead.
   assign rdata    = empty ? last_q : head;
   assign overflow = ovf_q;

   always_comb begin
      rd_ok    = rd && !empty;
      wr_ok    = wr && (!full || rd_ok);
      wr_ptr_d = wr_ptr_q;
      rd_ptr_d = rd_ptr_q;
      last_d   = last_q;
      ovf_d    = ovf_q;
      if (wr_ok) begin
         wr_ptr_d = wr_ptr_q + PTR_ONE;
      end
      if (rd_ok) begin
         rd_ptr_d = rd_ptr_q + PTR_ONE;
         last_d   = head;
      end
      if (wr && !wr_ok) begin
         ovf_d = 1'b1;
      end else if (clr) begin
         ovf_d = 1'b0;
      end
   end

   always_ff @(posedge clk or negedge resetb) begin
      if (!resetb) begin
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
         last_q   <= '0;
         ovf_q    <= 1'b0;
      end else begin
         wr_ptr_q <= wr_ptr_d;
         rd_ptr_q <= rd_ptr_d;
         last_q   <= last_d;
         ovf_q    <= ovf_d;
      end
   end

   always_ff @(posedge clk) begin
      if (wr_ok) begin
         mem_q[wr_ptr_q[ADDR_WIDTH-1:0]] <= wdata;
      end
   end

endmodule

// File: rtl/spi_burst_sequencer.sv
// Drains a TX FIFO word by word into spi_master and collects replies into an RX FIFO.
//   state | meaning
//   IDLE  | waiting for enable and a TX word
//   LOAD  | pop TX head into spi_datai
//   GO    | spi_go high for this cycle
//   ARM   | waiting for spi_busy (or an early spi_done)
//   XFER  | waiting for spi_done, capture spi_datao
//   STORE | push captured word to RX (drop if full)
module spi_burst_sequencer
   import spi_seq_pkg::*;
#(
   parameter int DATA_WIDTH = DEF_DATA_WIDTH,
   parameter int FIFO_DEPTH = DEF_FIFO_DEPTH,
   parameter int ADDR_WIDTH = $clog2(FIFO_DEPTH)
) (
   input  logic                  clk,
   input  logic                  resetb,
   input  logic                  enable,
   input  logic                  tx_wr,
   input  logic [DATA_WIDTH-1:0] tx_data,
   output logic                  tx_full,
   output logic [ADDR_WIDTH:0]   tx_level,
   input  logic                  rx_rd,
   output logic [DATA_WIDTH-1:0] rx_data,
   output logic                  rx_empty,
   output logic [ADDR_WIDTH:0]   rx_level,
   output logic                  tx_overflow,
   output logic                  rx_overflow,
   input  logic                  clear_err,
   output logic                  seq_busy,
   output logic                  spi_go,
   output logic [DATA_WIDTH-1:0] spi_datai,
   input  logic                  spi_busy,
   input  logic                  spi_done,
   input  logic [DATA_WIDTH-1:0] spi_datao
);

   seq_state_e            state_q, state_d;
   logic                  spi_go_q, spi_go_d;
   logic [DATA_WIDTH-1:0] spi_datai_q, spi_datai_d;
   logic [DATA_WIDTH-1:0] capt_q, capt_d;
   logic                  seq_busy_q, seq_busy_d;

   logic                  tx_rd, tx_empty;
   logic [DATA_WIDTH-1:0] tx_rdata;
   logic                  rx_wr;

   assign tx_rd = (state_q == LOAD);
   assign rx_wr = (state_q == STORE);

   spi_sync_fifo #(.DATA_WIDTH(DATA_WIDTH), .ADDR_WIDTH(ADDR_WIDTH)) u_tx_fifo (
      .clk      (clk),
      .resetb   (resetb),
      .wr       (tx_wr),
      .wdata    (tx_data),
      .rd       (tx_rd),
      .rdata    (tx_rdata),
      .full     (tx_full),
      .empty    (tx_empty),
      .level    (tx_level),
      .overflow (tx_overflow),
      .clr      (clear_err)
   );

   spi_sync_fifo #(.DATA_WIDTH(DATA_WIDTH), .ADDR_WIDTH(ADDR_WIDTH)) u_rx_fifo (
      .clk      (clk),
      .resetb   (resetb),
      .wr       (rx_wr),
      .wdata    (capt_q),
      .rd       (rx_rd),
      .rdata    (rx_data),
      .full     (),
      .empty    (rx_empty),
      .level    (rx_level),
      .overflow (rx_overflow),
      .clr      (clear_err)
   );

   always_comb begin
      state_d     = state_q;
      spi_go_d    = 1'b0;
      spi_datai_d = spi_datai_q;
      capt_d      = capt_q;
      case (state_q)
         IDLE: begin
            // Looking at tx_wr directly saves a cycle when the FIFO starts empty.
            if (enable && (!tx_empty || tx_wr)) begin
               state_d = LOAD;
            end
         end
         LOAD: begin
            spi_datai_d = tx_rdata;
            spi_go_d    = 1'b1;
            state_d     = GO;
         end
         GO: begin
            state_d = ARM;
         end
         ARM: begin
            if (spi_done) begin
               capt_d  = spi_datao;
               state_d = STORE;
            end else if (spi_busy) begin
               state_d = XFER;
            end
         end
         XFER: begin
            if (spi_done) begin
               capt_d  = spi_datao;
               state_d = STORE;
            end
         end
         STORE: begin
            state_d = IDLE;
         end
         default: begin
            state_d = IDLE;
         end
      endcase
      seq_busy_d = (state_d != IDLE);
   end

   always_ff @(posedge clk or negedge resetb) begin
      if (!resetb) begin
         state_q     <= IDLE;
         spi_go_q    <= 1'b0;
         spi_datai_q <= '0;
         capt_q      <= '0;
         seq_busy_q  <= 1'b0;
      end else begin
         state_q     <= state_d;
         spi_go_q    <= spi_go_d;
         spi_datai_q <= spi_datai_d;
         capt_q      <= capt_d;
         seq_busy_q  <= seq_busy_d;
      end
   end

   assign spi_go    = spi_go_q;
   assign spi_datai = spi_datai_q;
   assign seq_busy  = seq_busy_q;

endmodule

// File: tb/tb_spi_burst_sequencer.sv
// Bench for spi_burst_sequencer: scoreboard queues against an spi_master-like slave model.
module tb_spi_burst_sequencer;

   logic       clk;
   logic       resetb;
   logic       enable;
   logic       tx_wr;
   logic [7:0] tx_data;
   logic       tx_full;
   logic [3:0] tx_level;
   logic       rx_rd;
   logic [7:0] rx_data;
   logic       rx_empty;
   logic [3:0] rx_level;
   logic       tx_overflow;
   logic       rx_overflow;
   logic       clear_err;
   logic       seq_busy;
   logic       spi_go;
   logic [7:0] spi_datai;
   logic       spi_busy;
   logic       spi_done;
   logic [7:0] spi_datao;

   int n_checks = 0;
   int n_fail   = 0;

   logic [7:0] tx_exp[$];
   logic [7:0] rx_exp[$];

   int         sl_cnt     = 0;
   logic [7:0] sl_resp    = 8'h00;
   int         xfer_len   = 4;
   bit         short_mode = 1'b0;
   bit         check_gap  = 1'b0;
   int         cyc        = 0;
   int         done_cyc   = -1;
   int         go_count   = 0;
   logic [7:0] last_rx    = 8'h00;

   spi_burst_sequencer dut (
      .clk         (clk),
      .resetb      (resetb),
      .enable      (enable),
      .tx_wr       (tx_wr),
      .tx_data     (tx_data),
      .tx_full     (tx_full),
      .tx_level    (tx_level),
      .rx_rd       (rx_rd),
      .rx_data     (rx_data),
      .rx_empty    (rx_empty),
      .rx_level    (rx_level),
      .tx_overflow (tx_overflow),
      .rx_overflow (rx_overflow),
      .clear_err   (clear_err),
      .seq_busy    (seq_busy),
      .spi_go      (spi_go),
      .spi_datai   (spi_datai),
      .spi_busy    (spi_busy),
      .spi_done    (spi_done),
      .spi_datao   (spi_datao)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Slave model: busy the cycle after go, done in the last busy cycle; reply = word ^ 0xB4.
   initial begin
      logic [7:0] exp;
      spi_busy  = 1'b0;
      spi_done  = 1'b0;
      spi_datao = 8'h00;
      forever begin
         @(negedge clk);
         cyc++;
         if (!resetb) begin
            sl_cnt   = 0;
            spi_busy = 1'b0;
            spi_done = 1'b0;
            done_cyc = -1;
         end else begin
            spi_done = 1'b0;
            if (sl_cnt == 1) begin
               spi_done  = 1'b1;
               spi_datao = sl_resp;
               spi_busy  = !short_mode;
               sl_cnt    = 0;
               done_cyc  = cyc;
            end else if (sl_cnt > 1) begin
               spi_busy = 1'b1;
               sl_cnt--;
            end else begin
               spi_busy = 1'b0;
            end
            if (spi_go === 1'b1) begin
               n_checks++;
               if (sl_cnt != 0) begin
                  n_fail++;
                  $display("FAIL go_during_xfer: spi_go=%0b with transfer pending, required 0", spi_go);
               end
               n_checks++;
               if (tx_exp.size() == 0) begin
                  n_fail++;
                  exp = 8'h00;
                  $display("FAIL unexpected_go: spi_go with datai=%02h, required no pulse", spi_datai);
               end else begin
                  exp = tx_exp.pop_front();
                  if (spi_datai !== exp) begin
                     n_fail++;
                     $display("FAIL go_datai: got %02h, required %02h", spi_datai, exp);
                  end
               end
               if (check_gap && done_cyc >= 0) begin
                  n_checks++;
                  if (cyc - done_cyc != 4) begin
                     n_fail++;
                     $display("FAIL b2b_gap: done-to-go %0d cycles, required 4", cyc - done_cyc);
                  end
               end
               sl_resp = exp ^ 8'hB4;
               if (rx_exp.size() < 8) rx_exp.push_back(exp ^ 8'hB4);
               go_count++;
               sl_cnt = short_mode ? 1 : xfer_len;
            end
         end
      end
   end

   task automatic push(input logic [7:0] d);
      tx_wr   = 1'b1;
      tx_data = d;
      if (tx_exp.size() < 8) tx_exp.push_back(d);
      @(negedge clk);
      tx_wr = 1'b0;
   endtask

   task automatic wait_idle(input int max_cyc);
      int i;
      for (i = 0; i < max_cyc; i++) begin
         @(negedge clk);
         if (tx_level == 4'd0 && !seq_busy && sl_cnt == 0) break;
      end
      n_checks++;
      if (i >= max_cyc) begin
         n_fail++;
         $display("FAIL wait_idle_timeout: tx_level=%0d seq_busy=%0b after %0d cycles, required idle", tx_level, seq_busy, max_cyc);
      end
   endtask

   task automatic wait_go(input int target, input int max_cyc);
      int i;
      for (i = 0; i < max_cyc; i++) begin
         @(negedge clk);
         if (go_count >= target) break;
      end
      n_checks++;
      if (i >= max_cyc) begin
         n_fail++;
         $display("FAIL wait_go_timeout: go_count=%0d, required %0d", go_count, target);
      end
   endtask

   task automatic read_rx();
      logic [7:0] exp;
      n_checks++;
      if (rx_exp.size() == 0) begin
         n_fail++;
         $display("FAIL rx_read_model_empty: rx_data=%02h, required no word", rx_data);
      end else begin
         exp = rx_exp.pop_front();
         if (rx_empty !== 1'b0 || rx_data !== exp) begin
            n_fail++;
            $display("FAIL rx_read: got empty=%0b data=%02h, required empty=0 data=%02h", rx_empty, rx_data, exp);
         end
         last_rx = exp;
      end
      rx_rd = 1'b1;
      @(negedge clk);
      rx_rd = 1'b0;
   endtask

   task automatic test_reset();
      for (int i = 0; i < 6; i++) begin
         @(negedge clk);
         tx_wr   = ~tx_wr;
         tx_data = 8'hEE;
         n_checks++;
         if (spi_go !== 1'b0 || tx_level !== 4'd0 || rx_level !== 4'd0 || rx_empty !== 1'b1) begin
            n_fail++;
            $display("FAIL reset_hold: go=%0b txl=%0d rxl=%0d rxe=%0b, required 0/0/0/1", spi_go, tx_level, rx_level, rx_empty);
         end
      end
      tx_wr = 1'b0;
      @(negedge clk);
      resetb = 1'b1;
      repeat (4) @(negedge clk);
      n_checks++;
      if (seq_busy !== 1'b0 || spi_go !== 1'b0 || tx_level !== 4'd0 || rx_data !== 8'h00 ||
          spi_datai !== 8'h00 || tx_full !== 1'b0 || tx_overflow !== 1'b0 || rx_overflow !== 1'b0) begin
         n_fail++;
         $display("FAIL reset_release: busy=%0b go=%0b txl=%0d rxd=%02h datai=%02h full=%0b ovf=%0b%0b, required all 0",
                  seq_busy, spi_go, tx_level, rx_data, spi_datai, tx_full, tx_overflow, rx_overflow);
      end
   endtask

   task automatic test_single();
      enable = 1'b1;
      push(8'hA5);
      n_checks++;
      if (seq_busy !== 1'b1 || spi_go !== 1'b0) begin
         n_fail++;
         $display("FAIL single_load_cycle: busy=%0b go=%0b, required 1/0", seq_busy, spi_go);
      end
      @(negedge clk);
      n_checks++;
      if (spi_go !== 1'b1 || spi_datai !== 8'hA5) begin
         n_fail++;
         $display("FAIL single_go_cycle: go=%0b datai=%02h, required 1/a5", spi_go, spi_datai);
      end
      repeat (2) @(negedge clk);
      n_checks++;
      if (spi_go !== 1'b0 || spi_datai !== 8'hA5) begin
         n_fail++;
         $display("FAIL single_datai_hold: go=%0b datai=%02h, required 0/a5", spi_go, spi_datai);
      end
      wait_idle(100);
      n_checks++;
      if (rx_level !== 4'd1 || rx_data !== 8'h11) begin
         n_fail++;
         $display("FAIL single_rx: level=%0d data=%02h, required 1/11", rx_level, rx_data);
      end
      read_rx();
   endtask

   task automatic test_burst();
      int base = go_count;
      enable   = 1'b0;
      for (int i = 1; i <= 8; i++) push(8'(i));
      n_checks++;
      if (tx_full !== 1'b1 || tx_level !== 4'd8) begin
         n_fail++;
         $display("FAIL burst_fill: full=%0b level=%0d, required 1/8", tx_full, tx_level);
      end
      done_cyc  = -1;
      check_gap = 1'b1;
      enable    = 1'b1;
      wait_idle(400);
      check_gap = 1'b0;
      n_checks++;
      if (go_count - base != 8 || rx_level !== 4'd8 || tx_overflow !== 1'b0) begin
         n_fail++;
         $display("FAIL burst_done: gos=%0d rxl=%0d txovf=%0b, required 8/8/0", go_count - base, rx_level, tx_overflow);
      end
      for (int i = 0; i < 8; i++) read_rx();
   endtask

   task automatic test_overflow();
      enable = 1'b0;
      for (int i = 0; i < 9; i++) push(8'h50 + 8'(i));
      n_checks++;
      if (tx_overflow !== 1'b1 || tx_level !== 4'd8 || tx_full !== 1'b1) begin
         n_fail++;
         $display("FAIL tx_overflow: ovf=%0b level=%0d full=%0b, required 1/8/1", tx_overflow, tx_level, tx_full);
      end
      enable = 1'b1;
      wait_idle(400);
      n_checks++;
      if (rx_level !== 4'd8 || rx_overflow !== 1'b0) begin
         n_fail++;
         $display("FAIL rx_filled: level=%0d ovf=%0b, required 8/0", rx_level, rx_overflow);
      end
      push(8'h59);
      wait_idle(100);
      n_checks++;
      if (rx_overflow !== 1'b1 || rx_level !== 4'd8) begin
         n_fail++;
         $display("FAIL rx_overflow: ovf=%0b level=%0d, required 1/8", rx_overflow, rx_level);
      end
      clear_err = 1'b1;
      @(negedge clk);
      clear_err = 1'b0;
      n_checks++;
      if (tx_overflow !== 1'b0 || rx_overflow !== 1'b0) begin
         n_fail++;
         $display("FAIL clear_err: txovf=%0b rxovf=%0b, required 0/0", tx_overflow, rx_overflow);
      end
      for (int i = 0; i < 8; i++) read_rx();
      rx_rd = 1'b1;
      @(negedge clk);
      rx_rd = 1'b0;
      n_checks++;
      if (rx_empty !== 1'b1 || rx_level !== 4'd0 || rx_overflow !== 1'b0 || rx_data !== last_rx) begin
         n_fail++;
         $display("FAIL rx_rd_empty: empty=%0b level=%0d ovf=%0b data=%02h, required 1/0/0/%02h",
                  rx_empty, rx_level, rx_overflow, rx_data, last_rx);
      end
      enable = 1'b0;
      for (int i = 0; i < 8; i++) push(8'h60 + 8'(i));
      clear_err = 1'b1;
      push(8'h6F);
      clear_err = 1'b0;
      n_checks++;
      if (tx_overflow !== 1'b1) begin
         n_fail++;
         $display("FAIL set_beats_clear: txovf=%0b, required 1", tx_overflow);
      end
      clear_err = 1'b1;
      @(negedge clk);
      clear_err = 1'b0;
      enable = 1'b1;
      wait_idle(400);
      for (int i = 0; i < 8; i++) read_rx();
   endtask

   task automatic test_enable_drop();
      int base = go_count;
      xfer_len = 6;
      enable   = 1'b0;
      for (int i = 0; i < 4; i++) push(8'h21 + 8'(i));
      enable = 1'b1;
      wait_go(base + 2, 200);
      repeat (2) @(negedge clk);
      enable = 1'b0;
      repeat (40) @(negedge clk);
      n_checks++;
      if (go_count - base != 2 || tx_level !== 4'd2 || rx_level !== 4'd2 || seq_busy !== 1'b0) begin
         n_fail++;
         $display("FAIL enable_drop_hold: gos=%0d txl=%0d rxl=%0d busy=%0b, required 2/2/2/0",
                  go_count - base, tx_level, rx_level, seq_busy);
      end
      enable = 1'b1;
      wait_idle(200);
      n_checks++;
      if (go_count - base != 4 || rx_level !== 4'd4) begin
         n_fail++;
         $display("FAIL enable_resume: gos=%0d rxl=%0d, required 4/4", go_count - base, rx_level);
      end
      for (int i = 0; i < 4; i++) read_rx();
      xfer_len = 4;
   endtask

   task automatic test_short_xfer();
      short_mode = 1'b1;
      enable     = 1'b1;
      push(8'h77);
      push(8'h78);
      wait_idle(100);
      short_mode = 1'b0;
      n_checks++;
      if (rx_level !== 4'd2) begin
         n_fail++;
         $display("FAIL short_xfer: rx_level=%0d, required 2", rx_level);
      end
      for (int i = 0; i < 2; i++) read_rx();
   endtask

   task automatic test_async_reset();
      int base;
      xfer_len = 12;
      enable   = 1'b1;
      push(8'h3C);
      wait_idle(100);
      enable = 1'b0;
      push(8'h40);
      push(8'h41);
      push(8'h42);
      base   = go_count;
      enable = 1'b1;
      wait_go(base + 1, 50);
      repeat (3) @(negedge clk);
      #2;
      resetb = 1'b0;
      #1;
      n_checks++;
      if (spi_go !== 1'b0 || spi_datai !== 8'h00 || seq_busy !== 1'b0 || tx_level !== 4'd0 ||
          tx_full !== 1'b0 || rx_empty !== 1'b1 || rx_level !== 4'd0 || rx_data !== 8'h00 ||
          tx_overflow !== 1'b0 || rx_overflow !== 1'b0) begin
         n_fail++;
         $display("FAIL async_reset: go=%0b datai=%02h busy=%0b txl=%0d full=%0b rxe=%0b rxl=%0d rxd=%02h ovf=%0b%0b, required reset values",
                  spi_go, spi_datai, seq_busy, tx_level, tx_full, rx_empty, rx_level, rx_data, tx_overflow, rx_overflow);
      end
      tx_exp.delete();
      rx_exp.delete();
      repeat (3) @(negedge clk);
      resetb   = 1'b1;
      xfer_len = 4;
      @(negedge clk);
      push(8'h5A);
      wait_idle(100);
      n_checks++;
      if (rx_level !== 4'd1) begin
         n_fail++;
         $display("FAIL post_reset_xfer: rx_level=%0d, required 1", rx_level);
      end
      read_rx();
   endtask

   initial begin
      resetb    = 1'b1;
      enable    = 1'b0;
      tx_wr     = 1'b0;
      tx_data   = 8'h00;
      rx_rd     = 1'b0;
      clear_err = 1'b0;
      #1 resetb = 1'b0;
      test_reset();
      test_single();
      test_burst();
      test_overflow();
      test_enable_drop();
      test_short_xfer();
      test_async_reset();
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
